// File: rtl/ats21_pkg.sv
// rtl/ats21_pkg.sv - shared widths, states and command/response types for the ATS21 arbiter
package ats21_pkg;

   localparam int CTRL_W = 16;
   localparam int STAT_W = 2;
   localparam int DATA_W = 24;
   localparam logic [STAT_W-1:0] STAT_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
   typedef enum logic {CLIENT_A, CLIENT_B} client_t;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrlA;
      logic [CTRL_W-1:0] ctrlB;
   } ats_cmd_t;

   typedef struct packed {
      logic [STAT_W-1:0] stat;
      logic [DATA_W-1:0] data;
   } ats_rsp_t;

endpackage

// File: rtl/ats21_client_port.sv
// rtl/ats21_client_port.sv - one-deep command holding register and response register for one client
module ats21_client_port
   import ats21_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CTRL_W-1:0] ctrlA,
   input  logic [CTRL_W-1:0] ctrlB,
   output ats_cmd_t          cmd,
   output logic              pend,
   input  logic              done,
   input  logic              rsp_load,
   input  ats_rsp_t          rsp_in,
   output logic              rsp_valid,
   output logic [STAT_W-1:0] rsp_stat,
   output logic [DATA_W-1:0] rsp_data
);

   ats_rsp_t rsp_q;

   assign req_ready = ~pend;
   assign rsp_stat  = rsp_q.stat;
   assign rsp_data  = rsp_q.data;

   // done only arrives while pend is set, so it never races a new accept
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend <= 1'b0;
         cmd  <= '0;
      end else if (done) begin
         pend <= 1'b0;
      end else if (req_valid && req_ready) begin
         pend      <= 1'b1;
         cmd.ctrlA <= ctrlA;
         cmd.ctrlB <= ctrlB;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid <= 1'b0;
         rsp_q     <= '0;
      end else begin
         rsp_valid <= rsp_load;
         if (rsp_load) rsp_q <= rsp_in;
      end
   end

endmodule

// File: rtl/ats21_cmd_arbiter.sv
// rtl/ats21_cmd_arbiter.sv - round-robin sharing of one ATS21 command interface between clients A and B
module ats21_cmd_arbiter
   import ats21_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TO_BITS        = $clog2(TIMEOUT_CYCLES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req_valid,
   output logic              a_req_ready,
   input  logic [CTRL_W-1:0] a_ctrlA,
   input  logic [CTRL_W-1:0] a_ctrlB,
   output logic              a_rsp_valid,
   output logic [STAT_W-1:0] a_rsp_stat,
   output logic [DATA_W-1:0] a_rsp_data,
   input  logic              b_req_valid,
   output logic              b_req_ready,
   input  logic [CTRL_W-1:0] b_ctrlA,
   input  logic [CTRL_W-1:0] b_ctrlB,
   output logic              b_rsp_valid,
   output logic [STAT_W-1:0] b_rsp_stat,
   output logic [DATA_W-1:0] b_rsp_data,
   output logic              ats_req,
   output logic [CTRL_W-1:0] ats_ctrlA,
   output logic [CTRL_W-1:0] ats_ctrlB,
   input  logic              ats_ready,
   input  logic [STAT_W-1:0] ats_stat,
   input  logic [DATA_W-1:0] ats_data,
   output logic              timeout_err,
   output logic              busy
);

   arb_state_t         state_q, state_d;
   client_t            grant_q, grant_d, last_q, last_d;
   logic [TO_BITS-1:0] timer_q, timer_d;
   ats_cmd_t           cmd_q, cmd_d, a_cmd, b_cmd;
   ats_rsp_t           rsp_d;
   logic               a_pend, b_pend, rsp_load, done;

   ats21_client_port u_port_a (
      .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .ctrlA(a_ctrlA), .ctrlB(a_ctrlB), .cmd(a_cmd), .pend(a_pend),
      .done(done && grant_q == CLIENT_A), .rsp_load(rsp_load && grant_q == CLIENT_A),
      .rsp_in(rsp_d), .rsp_valid(a_rsp_valid), .rsp_stat(a_rsp_stat), .rsp_data(a_rsp_data)
   );

   ats21_client_port u_port_b (
      .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .ctrlA(b_ctrlA), .ctrlB(b_ctrlB), .cmd(b_cmd), .pend(b_pend),
      .done(done && grant_q == CLIENT_B), .rsp_load(rsp_load && grant_q == CLIENT_B),
      .rsp_in(rsp_d), .rsp_valid(b_rsp_valid), .rsp_stat(b_rsp_stat), .rsp_data(b_rsp_data)
   );

   assign ats_req   = (state_q == ISSUE);
   assign ats_ctrlA = cmd_q.ctrlA;
   assign ats_ctrlB = cmd_q.ctrlB;
   assign busy      = (state_q != IDLE);

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      timer_d     = timer_q;
      cmd_d       = cmd_q;
      rsp_d       = '0;
      rsp_load    = 1'b0;
      done        = 1'b0;
      timeout_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (a_pend || b_pend) begin
               grant_d = (a_pend && (!b_pend || last_q == CLIENT_B)) ? CLIENT_A : CLIENT_B;
               cmd_d   = (grant_d == CLIENT_A) ? a_cmd : b_cmd;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // a ready arriving on the last timer cycle still wins over the timeout
            if (ats_ready) begin
               rsp_d    = '{stat: ats_stat, data: ats_data};
               rsp_load = 1'b1;
               state_d  = RESP;
            end else if (timer_q == TO_BITS'(TIMEOUT_CYCLES - 1)) begin
               rsp_d       = '{stat: STAT_TIMEOUT, data: '0};
               rsp_load    = 1'b1;
               timeout_err = 1'b1;
               state_d     = RESP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         RESP: begin
            done    = 1'b1;
            last_d  = grant_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= CLIENT_A;
         last_q  <= CLIENT_B;
         timer_q <= '0;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         timer_q <= timer_d;
         cmd_q   <= cmd_d;
      end
   end

endmodule

// File: tb/tb_ats21_cmd_arbiter.sv
// tb/tb_ats21_cmd_arbiter.sv - directed and randomized self-checking bench for ats21_cmd_arbiter
module tb_ats21_cmd_arbiter;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_req_valid, a_req_ready, a_rsp_valid;
   logic [15:0] a_ctrlA, a_ctrlB;
   logic [1:0]  a_rsp_stat;
   logic [23:0] a_rsp_data;
   logic        b_req_valid, b_req_ready, b_rsp_valid;
   logic [15:0] b_ctrlA, b_ctrlB;
   logic [1:0]  b_rsp_stat;
   logic [23:0] b_rsp_data;
   logic        ats_req, ats_ready, timeout_err, busy;
   logic [15:0] ats_ctrlA, ats_ctrlB;
   logic [1:0]  ats_stat;
   logic [23:0] ats_data;

   int checks = 0;
   int errors = 0;
   int last   = 1;

   always #5 clk = ~clk;

   ats21_cmd_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_ctrlA(a_ctrlA), .a_ctrlB(a_ctrlB),
      .a_rsp_valid(a_rsp_valid), .a_rsp_stat(a_rsp_stat), .a_rsp_data(a_rsp_data),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_ctrlA(b_ctrlA), .b_ctrlB(b_ctrlB),
      .b_rsp_valid(b_rsp_valid), .b_rsp_stat(b_rsp_stat), .b_rsp_data(b_rsp_data),
      .ats_req(ats_req), .ats_ctrlA(ats_ctrlA), .ats_ctrlB(ats_ctrlB),
      .ats_ready(ats_ready), .ats_stat(ats_stat), .ats_data(ats_data),
      .timeout_err(timeout_err), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // round-robin rule: a lone requester wins; on a tie the client that was not served last wins
   function automatic int pick(input bit pa, input bit pb, input int last_c);
      if (pa && pb) return (last_c == 0) ? 1 : 0;
      return pa ? 0 : 1;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic junk_ready();
      ats_ready = 1'($urandom_range(0, 1));
      ats_stat  = 2'($urandom);
      ats_data  = 24'($urandom);
   endtask

   task automatic submit(input bit sa, input bit sb, input logic [31:0] ca, input logic [31:0] cb);
      a_req_valid = sa; {a_ctrlA, a_ctrlB} = ca;
      b_req_valid = sb; {b_ctrlA, b_ctrlB} = cb;
      junk_ready();
      cyc();
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      @(negedge clk);
      if (sa) chk("accept_a_ready", 32'(a_req_ready), 0);
      if (sb) chk("accept_b_ready", 32'(b_req_ready), 0);
      chk("accept_busy", 32'(busy), 0);
   endtask

   // called in an IDLE cycle with something pending; returns in the following IDLE cycle
   task automatic txn(input int c, input logic [31:0] cmd, input int lat,
                      input logic [1:0] st, input logic [23:0] dt, input bit keep);
      bit          to;
      logic [1:0]  es;
      logic [23:0] ed;
      to = (lat >= TO);
      es = to ? 2'b11 : st;
      ed = to ? 24'h0 : dt;
      cyc();
      if (!keep) begin a_req_valid = 1'b0; b_req_valid = 1'b0; end
      junk_ready();
      @(negedge clk);
      chk("issue_req", 32'(ats_req), 1);
      chk("issue_ctrl", {ats_ctrlA, ats_ctrlB}, cmd);
      chk("issue_busy", 32'(busy), 1);
      for (int i = 0; i < (to ? TO - 1 : lat); i++) begin
         cyc();
         ats_ready = 1'b0;
         @(negedge clk);
         chk("wait_req", 32'(ats_req), 0);
         chk("wait_no_timeout", 32'(timeout_err), 0);
      end
      cyc();
      if (to) ats_ready = 1'b0;
      else begin ats_ready = 1'b1; ats_stat = st; ats_data = dt; end
      @(negedge clk);
      chk("final_wait_timeout_err", 32'(timeout_err), 32'(to));
      chk("final_wait_ctrl_hold", {ats_ctrlA, ats_ctrlB}, cmd);
      cyc();
      junk_ready();
      @(negedge clk);
      chk("resp_valid", 32'(c == 0 ? a_rsp_valid : b_rsp_valid), 1);
      chk("resp_other_quiet", 32'(c == 0 ? b_rsp_valid : a_rsp_valid), 0);
      chk("resp_stat", 32'(c == 0 ? a_rsp_stat : b_rsp_stat), 32'(es));
      chk("resp_data", 32'(c == 0 ? a_rsp_data : b_rsp_data), 32'(ed));
      chk("resp_ready_low", 32'(c == 0 ? a_req_ready : b_req_ready), 0);
      cyc();
      ats_ready = 1'b0;
      @(negedge clk);
      chk("post_valid_low", 32'(c == 0 ? a_rsp_valid : b_rsp_valid), 0);
      chk("post_ready_high", 32'(c == 0 ? a_req_ready : b_req_ready), 1);
      chk("post_stat_hold", 32'(c == 0 ? a_rsp_stat : b_rsp_stat), 32'(es));
      chk("post_data_hold", 32'(c == 0 ? a_rsp_data : b_rsp_data), 32'(ed));
      chk("post_busy", 32'(busy), 0);
      last = c;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ca, cb, cur [2];
      bit          pa, pb;
      int          c;

      reset = 1'b0;
      a_req_valid = 1'b0; a_ctrlA = '0; a_ctrlB = '0;
      b_req_valid = 1'b0; b_ctrlA = '0; b_ctrlB = '0;
      ats_ready = 1'b0; ats_stat = '0; ats_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_a_ready", 32'(a_req_ready), 1);
      chk("rst_b_ready", 32'(b_req_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ats_req", 32'(ats_req), 0);
      chk("rst_ctrl", {ats_ctrlA, ats_ctrlB}, 0);
      chk("rst_rsp", {30'(0), a_rsp_valid, b_rsp_valid}, 0);
      chk("rst_timeout", 32'(timeout_err), 0);
      reset = 1'b1;

      // simultaneous pair right after reset: A wins the first tie
      submit(1, 1, 32'hA0A0_0001, 32'hB0B0_0002);
      chk("first_tie_grant", 32'(pick(1, 1, last)), 0);
      txn(0, 32'hA0A0_0001, 1, 2'b10, 24'h111111, 0);
      txn(pick(0, 1, last), 32'hB0B0_0002, 2, 2'b00, 24'h222222, 0);

      // single A command, ready in the first WAIT cycle
      submit(1, 0, 32'h1234_00FF, 32'h0);
      txn(0, 32'h1234_00FF, 0, 2'b01, 24'hABCDEF, 0);

      // second A command held while the first is pending
      submit(1, 0, 32'h5555_6666, 32'h0);
      a_req_valid = 1'b1; {a_ctrlA, a_ctrlB} = 32'h7777_8888;
      txn(0, 32'h5555_6666, 1, 2'b00, 24'h0F0F0F, 1);
      cyc();
      a_req_valid = 1'b0;
      @(negedge clk);
      chk("second_accept_ready", 32'(a_req_ready), 0);
      txn(0, 32'h7777_8888, 0, 2'b10, 24'h123456, 0);

      // 8 continuous pairs, freed client resubmits immediately
      cur[0] = $urandom; cur[1] = $urandom;
      submit(1, 1, cur[0], cur[1]);
      for (int k = 0; k < 16; k++) begin
         c = pick(1, 1, last);
         txn(c, cur[c], 0, 2'($urandom), 24'($urandom), 0);
         if (k < 14) begin
            cur[c] = $urandom;
            if (c == 0) begin a_req_valid = 1'b1; {a_ctrlA, a_ctrlB} = cur[0]; end
            else begin b_req_valid = 1'b1; {b_ctrlA, b_ctrlB} = cur[1]; end
         end
      end

      // randomized rounds
      for (int r = 0; r < 12; r++) begin
         c  = $urandom_range(0, 2);
         pa = (c != 1); pb = (c != 0);
         ca = $urandom; cb = $urandom;
         submit(pa, pb, ca, cb);
         while (pa || pb) begin
            c = pick(pa, pb, last);
            txn(c, c == 0 ? ca : cb, $urandom_range(0, 4), 2'($urandom), 24'($urandom), 0);
            if (c == 0) pa = 1'b0; else pb = 1'b0;
         end
      end

      // timeout on the first of a pair, the other completes normally
      submit(1, 1, 32'hDEAD_0001, 32'hBEEF_0002);
      c = pick(1, 1, last);
      txn(c, c == 0 ? 32'hDEAD_0001 : 32'hBEEF_0002, TO, 2'b01, 24'h999999, 0);
      c = 1 - c;
      txn(c, c == 0 ? 32'hDEAD_0001 : 32'hBEEF_0002, 1, 2'b01, 24'h777777, 0);

      // ready on the final timer cycle beats the timeout
      submit(1, 0, 32'hC0DE_0003, 32'h0);
      txn(0, 32'hC0DE_0003, TO - 1, 2'b10, 24'h5A5A5A, 0);

      // reset during ISSUE aborts the transaction
      submit(1, 0, 32'hF00D_0004, 32'h0);
      cyc();
      @(negedge clk);
      chk("pre_reset_req", 32'(ats_req), 1);
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset_req", 32'(ats_req), 0);
      chk("async_reset_busy", 32'(busy), 0);
      chk("async_reset_a_ready", 32'(a_req_ready), 1);
      chk("async_reset_b_ready", 32'(b_req_ready), 1);
      ats_ready = 1'b1; ats_stat = 2'b01; ats_data = 24'h333333;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      last = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("aborted_no_rsp", {30'(0), a_rsp_valid, b_rsp_valid}, 0);
      end
      ats_ready = 1'b0;
      submit(1, 1, 32'h0101_0202, 32'h0303_0404);
      txn(pick(1, 1, last), 32'h0101_0202, 0, 2'b00, 24'h444444, 0);
      txn(1, 32'h0303_0404, 0, 2'b11, 24'h555555, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ats21_cmd_arbiter.md
Name: ats21_cmd_arbiter

Overview:
- Shares one ATS21 command interface (req/ctrlA/ctrlB/ready/stat/data) between two requesting clients, A and B.
- Buffers one command per client, grants round-robin, and issues a single-cycle req to the ATS21.
- Waits for ready with a timeout, then routes the captured stat/data back to the granted client.
- Sits between the system-side clients and the ATS21 instance.

Parameters:
TIMEOUT_CYCLES, 64, WAIT-state cycles before the transaction is aborted with a timeout status (min 2)
TO_BITS, $clog2(TIMEOUT_CYCLES), timeout counter width

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
a_req_valid  input  1  client A has a command
a_req_ready  output  1  client A holding register empty
a_ctrlA  input  16  client A command word A
a_ctrlB  input  16  client A command word B
a_rsp_valid  output  1  one-cycle response pulse to A
a_rsp_stat  output  2  response status to A
a_rsp_data  output  24  response data to A
b_req_valid, b_req_ready, b_ctrlA, b_ctrlB, b_rsp_valid, b_rsp_stat, b_rsp_data: same as the A ports, for client B
ats_req  output  1  command strobe to ATS21
ats_ctrlA  output  16  command word A to ATS21
ats_ctrlB  output  16  command word B to ATS21
ats_ready  input  1  ATS21 completion
ats_stat  input  2  ATS21 status
ats_data  input  24  ATS21 data
timeout_err  output  1  one-cycle pulse on timeout
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (reset==0, asynchronous):
  - FSM=IDLE; both pend=0; last_grant=B, so A wins the first tie.
  - All outputs 0 except x_req_ready=1.
  - Reset mid-transaction aborts it: ats_req drops immediately and no response is ever delivered.
- Client port:
  - x_req_ready = ~x_pend.
  - On x_req_valid & x_req_ready, ctrlA/ctrlB are latched and pend=1.
  - Holding-register contents are frozen while pend=1.
- FSM IDLE:
  - If no pend, stay.
  - If one pend, grant that client.
  - If both pend, grant the client != last_grant.
  - Next state ISSUE.
- FSM ISSUE:
  - ats_req=1 for exactly this one cycle; ats_ctrlA/B = granted holding register.
  - ats_ready is ignored in this cycle.
  - Timer cleared; next state WAIT.
- FSM WAIT:
  - ats_req=0; ats_ctrlA/B hold their values.
  - If ats_ready=1: capture ats_stat/ats_data, go to RESP.
  - Else timer+1. When timer reaches TIMEOUT_CYCLES-1 with no ready: stat=2'b11 (STAT_TIMEOUT), data=0, timeout_err=1 for one cycle, go to RESP.
  - ats_ready in the same cycle as the timeout takes priority over the timeout.
- FSM RESP:
  - Granted x_rsp_valid=1 for one cycle, with x_rsp_stat/x_rsp_data = captured values. Non-granted client rsp_valid stays 0.
  - Granted pend cleared; last_grant=granted; next state IDLE.
  - rsp_stat/rsp_data hold until that client's next response.
- ats_ready outside WAIT is ignored and has no side effects.
- Latency, request accepted at edge E0:
  - ats_req high in the cycle after E1.
  - With ats_ready in the first WAIT cycle, rsp_valid is high in the cycle after E3.
  - Freed x_req_ready is high the cycle after RESP.
- Back-to-back with both clients continuously pending: grants strictly alternate A,B,A,B; 4 cycles per transaction with no stalls.
- busy = (state != IDLE).

Decomposition:
- Package ats21_pkg:
  - CTRL_W=16, STAT_W=2, DATA_W=24, STAT_TIMEOUT=2'b11
  - typedef enum arb_state_t {IDLE, ISSUE, WAIT, RESP}
  - typedef enum client_t {CLIENT_A, CLIENT_B}
  - packed struct ats_cmd_t {ctrlA, ctrlB}
  - packed struct ats_rsp_t {stat, data}
- Sub-module ats21_client_port (holding register, pend flag, ready/valid accept, response register), instantiated twice.
- Arbiter FSM, timer and mux live in the top module.

Test Plan:
- Reset low mid-WAIT of an A command -> ats_req=0 immediately; no a_rsp_valid ever; after release a_req_ready=b_req_ready=1, busy=0.
- A sends ctrlA=16'h1234, ctrlB=16'h00FF; ATS21 model gives ready 1 cycle after req with stat=2'b01, data=24'hABCDEF -> ats_req one cycle with matching ctrl; a_rsp_valid pulse 3 cycles after accept with stat=01, data=ABCDEF; b_rsp_valid=0.
- A and B valid on the same edge after reset -> A issued first, then B; B then A on the next simultaneous pair; 8 continuous pairs give a strict A,B alternation.
- A sends a second command while pend=1 -> a_req_ready=0, command not taken until after a_rsp_valid; second ats_req carries the second command values.
- ATS21 never asserts ready, TIMEOUT_CYCLES=64 -> timeout_err pulse 64 WAIT cycles after ISSUE; a_rsp_stat=2'b11, data=0; next pending B issued normally.
- ats_ready pulsed in IDLE and ISSUE, then a real ready in WAIT -> spurious pulses ignored; exactly one response with data captured from the WAIT-cycle ready.
